// File: rtl/hram_cache_pkg.sv
`default_nettype none
// ============================================================================
// hram_cache_pkg
// Shared state encoding, address field positions and counter helper.
// Revision: 1.0
// ============================================================================
package hram_cache_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOOKUP = 3'd1,
    ST_FILL   = 3'd2,
    ST_WRITE  = 3'd3,
    ST_MDROP  = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  localparam int c_IDX_LSB = 2;
  localparam int c_TAG_MSB = 25;
  localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == c_CNT_MAX) ? v : v + 16'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hram_cache_array.sv
`default_nettype none
// ============================================================================
// hram_cache_array
// Tag and byte-lane data storage, one synchronous read and one write port.
// Revision: 1.0
// ============================================================================
module hram_cache_array #(
  parameter int LINES = 16,
  parameter int IDX_W = $clog2(LINES),
  parameter int TAG_W = 24 - IDX_W
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic [TAG_W-1:0] o_rd_tag,
  output logic [31:0]      o_rd_data,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic             i_tag_we,
  input  logic [TAG_W-1:0] i_wr_tag,
  input  logic [3:0]       i_wr_be,
  input  logic [31:0]      i_wr_data
);

  logic [TAG_W-1:0] r_tag_mem [LINES];

  always_ff @(posedge clk) begin
    if (i_tag_we) r_tag_mem[i_wr_idx] <= i_wr_tag;
    o_rd_tag <= r_tag_mem[i_rd_idx];
  end

  // One narrow memory per byte lane keeps the byte enable RAM-friendly.
  generate
    for (genvar b = 0; b < 4; b++) begin : g_lane
      logic [7:0] r_mem [LINES];
      logic [7:0] r_rd;
      always_ff @(posedge clk) begin
        if (i_wr_be[b]) r_mem[i_wr_idx] <= i_wr_data[8*b +: 8];
        r_rd <= r_mem[i_rd_idx];
      end
      assign o_rd_data[8*b +: 8] = r_rd;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/hram_cache.sv
`default_nettype none
// ============================================================================
// hram_cache
// Direct-mapped write-through read cache in front of the hram controller.
// Revision: 1.0
// ============================================================================
module hram_cache
  import hram_cache_pkg::*;
#(
  parameter int LINES = 16,
  parameter int IDX_W = $clog2(LINES),
  parameter int TAG_W = 24 - IDX_W
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid,
  output logic        ready,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic [31:0] rdata,
  input  logic        inval,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  output logic [15:0] hit_cnt,
  output logic [15:0] miss_cnt
);

  state_t           r_state;
  logic             r_phase;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic [3:0]       r_wstrb;
  logic             r_hit;
  logic [LINES-1:0] r_vbits;
  logic             r_inv_pend;
  logic             r_ready;
  logic [31:0]      r_rdata;
  logic             r_mem_valid;
  logic [31:0]      r_mem_addr;
  logic [31:0]      r_mem_wdata;
  logic [3:0]       r_mem_wstrb;
  logic [15:0]      r_hit_cnt;
  logic [15:0]      r_miss_cnt;

  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic [TAG_W-1:0] w_arr_tag;
  logic [31:0]      w_arr_data;
  logic             w_lookup_hit;
  logic             w_fill_we;
  logic             w_merge_we;
  logic [3:0]       w_be;
  logic [31:0]      w_wr_data;

  assign w_idx        = r_addr[c_IDX_LSB +: IDX_W];
  assign w_tag        = r_addr[c_TAG_MSB : c_IDX_LSB + IDX_W];
  assign w_lookup_hit = r_vbits[w_idx] && (w_arr_tag == w_tag);
  assign w_fill_we    = (r_state == ST_FILL) && mem_ready;
  assign w_merge_we   = (r_state == ST_WRITE) && mem_ready && r_hit;
  assign w_be         = w_fill_we ? 4'hF : (w_merge_we ? r_wstrb : 4'h0);
  assign w_wr_data    = w_fill_we ? mem_rdata : r_wdata;

  hram_cache_array #(
    .LINES (LINES),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_array (
    .clk       (clk),
    .i_rd_idx  (w_idx),
    .o_rd_tag  (w_arr_tag),
    .o_rd_data (w_arr_data),
    .i_wr_idx  (w_idx),
    .i_tag_we  (w_fill_we),
    .i_wr_tag  (w_tag),
    .i_wr_be   (w_be),
    .i_wr_data (w_wr_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_phase     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_hit       <= 1'b0;
      r_vbits     <= '0;
      r_inv_pend  <= 1'b0;
      r_ready     <= 1'b0;
      r_rdata     <= '0;
      r_mem_valid <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wstrb <= '0;
      r_hit_cnt   <= '0;
      r_miss_cnt  <= '0;
    end else begin
      if (inval) r_inv_pend <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (r_inv_pend) begin
            // The clear cycle takes no request; a fresh pulse re-arms it.
            r_vbits    <= '0;
            r_inv_pend <= inval;
          end else if (valid && !r_ready) begin
            r_addr  <= addr;
            r_wdata <= wdata;
            r_wstrb <= wstrb;
            r_phase <= 1'b0;
            r_state <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          // First cycle lets the synchronous array read settle.
          if (!r_phase) begin
            r_phase <= 1'b1;
          end else begin
            r_hit <= w_lookup_hit;
            if (r_wstrb == 4'h0) begin
              if (w_lookup_hit) begin
                r_rdata   <= w_arr_data;
                r_ready   <= 1'b1;
                r_hit_cnt <= sat_inc(r_hit_cnt);
                r_state   <= ST_DONE;
              end else if (!mem_ready) begin
                r_mem_valid <= 1'b1;
                r_mem_addr  <= r_addr;
                r_mem_wdata <= r_wdata;
                r_mem_wstrb <= 4'h0;
                r_miss_cnt  <= sat_inc(r_miss_cnt);
                r_state     <= ST_FILL;
              end
            end else if (!mem_ready) begin
              r_mem_valid <= 1'b1;
              r_mem_addr  <= r_addr;
              r_mem_wdata <= r_wdata;
              r_mem_wstrb <= r_wstrb;
              r_state     <= ST_WRITE;
            end
          end
        end
        ST_FILL: begin
          if (mem_ready) begin
            r_vbits[w_idx] <= 1'b1;
            r_rdata        <= mem_rdata;
            r_mem_valid    <= 1'b0;
            r_state        <= ST_MDROP;
          end
        end
        ST_WRITE: begin
          if (mem_ready) begin
            r_mem_valid <= 1'b0;
            r_state     <= ST_MDROP;
          end
        end
        ST_MDROP: begin
          if (!mem_ready) begin
            r_ready <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (!valid) begin
            r_ready <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ready     = r_ready;
  assign rdata     = r_rdata;
  assign mem_valid = r_mem_valid;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_wstrb = r_mem_wstrb;
  assign hit_cnt   = r_hit_cnt;
  assign miss_cnt  = r_miss_cnt;

endmodule
`default_nettype wire

// File: doc/hram_cache.md
# hram_cache

Direct-mapped, write-through read cache between the CPU bus and the `hram` PSRAM controller. It serves read hits from on-chip storage in 2 cycles and forwards misses and all writes to `hram` over the same valid/ready bus. Write hits update the cached word byte-wise. It also keeps saturating hit and miss counters for software profiling.

## Interface

- `LINES`, 16: number of one-word lines; power of two, 4..256.
- `IDX_W`, $clog2(LINES): index width.
- `TAG_W`, 24 − IDX_W: tag width, covering `addr[25:2+IDX_W]`.

Ports:

- `clk` in 1: the block's only clock.
- `reset` in 1: asynchronous, active-high reset.
- `valid` in 1: CPU request.
- `ready` out 1: CPU response.
- `addr` in 32: CPU byte address. Bits [1:0] are ignored for lookup.
- `wdata` in 32: CPU write data.
- `wstrb` in 4: byte strobes. Zero means read.
- `rdata` out 32: read data, valid while `ready` is high.
- `inval` in 1: single-cycle pulse that invalidates all lines.
- `mem_valid` out 1: request to `hram`.
- `mem_ready` in 1: `hram` response.
- `mem_addr` out 32: `addr` forwarded unchanged.
- `mem_wdata` out 32: `wdata` forwarded unchanged.
- `mem_wstrb` out 4: `wstrb` forwarded unchanged. Zero for a fill.
- `mem_rdata` in 32: `hram` read data.
- `hit_cnt` out 16: saturating hit counter.
- `miss_cnt` out 16: saturating miss counter.

## Operation

- Both buses use the same four-phase protocol:
  - The master raises `valid` and holds it with the request fields stable.
  - The slave raises `ready` and holds it until it samples `valid` low.
  - The slave drops `ready` on the cycle after it samples `valid` low.
- Address fields: `idx = addr[IDX_W+1:2]`, `tag = addr[25:IDX_W+2]`. Bits [31:26] are not compared.
- Storage:
  - `vbits[LINES-1:0]` are flops with asynchronous clear.
  - The tag and data arrays are not reset.
- FSM states:
  - **IDLE**: if `valid && !ready`, latch addr/wdata/wstrb, then go to LOOKUP.
  - **LOOKUP**: register `hit = vbits[idx] && tag_q == tag`.
    - Read hit: `rdata` ← line data, `ready` ← 1, `hit_cnt`++, go to DONE.
    - Read miss: `mem_valid` ← 1, `mem_wstrb` ← 0, `miss_cnt`++, go to FILL.
    - Write: `mem_valid` ← 1 with the CPU strobes, go to WRITE. The counters are unchanged.
  - **FILL**: on `mem_ready`:
    - Write `mem_rdata` into the data array at idx, write the tag, set `vbits[idx]`.
    - `rdata` ← `mem_rdata`, `mem_valid` ← 0, go to MDROP.
  - **WRITE**: on `mem_ready`:
    - If the registered hit is set, merge `wdata` into the line per `wstrb`.
    - A write miss does not allocate.
    - `mem_valid` ← 0, go to MDROP.
  - **MDROP**: wait for `mem_ready` low, then `ready` ← 1, go to DONE.
  - **DONE**: when `valid` is sampled low, `ready` ← 0, go to IDLE.
- `inval`:
  - A pulse in any state sets a sticky pending flag.
  - The flag clears all `vbits` on the next cycle spent in IDLE. That cycle does not accept a request.
  - A fill that completes in the same cycle as the clear leaves its line invalid.
- Counters stop at 16'hFFFF. They clear only on `reset`.
- Asynchronous `reset`:
  - State → IDLE.
  - `ready`, `mem_valid`, `vbits`, the counters and the pending flag → 0.
  - `rdata` → 0.
  - `mem_addr`, `mem_wdata` and `mem_wstrb` → 0.
  - A `hram` transaction cut off by reset is abandoned. `hram` recovers through its own reset.

## Timing

- Read hit: `valid` sampled at edge 0, `ready` high after edge 2.
- Read miss: `mem_valid` rises after edge 2. CPU `ready` rises 2 cycles after the edge that samples `mem_ready` high.
- Write: CPU `ready` rises 2 cycles after the edge that samples `mem_ready` high.
- Back-to-back requests: the minimum gap is 1 IDLE cycle after `ready` falls.
- `mem_valid` is never raised while `mem_ready` is still high.

## Structure

- `hram_cache_pkg` holds:
  - the state enum (IDLE, LOOKUP, FILL, WRITE, MDROP, DONE);
  - the localparams for the address field positions.
- Sub-module `hram_cache_array` holds the tag and data arrays:
  - one synchronous read port and one write port;
  - a byte write enable;
  - suitable for block-RAM inference.

## Test plan

- **Cold read then hit:** after reset, read 0x00000040.
  - Expect one `mem_valid` request with `mem_wstrb` = 0; `hram` returns 0xDEADBEEF.
  - Expect `rdata` = 0xDEADBEEF and `miss_cnt` = 1.
  - Repeat the read. Expect no `mem_valid`, `ready` 2 cycles after `valid`, and `hit_cnt` = 1.
- **Write hit merge:** with the line above cached, write 0x000000AA to 0x00000040 with `wstrb` = 4'b0001.
  - Expect the write forwarded to `hram`.
  - A following read returns 0xDEADBEAA with no memory access.
- **Write miss, no allocate:** write to 0x00000080, then read it back. Expect the read to miss and go to memory.
- **Conflict and invalidate:**
  - Read 0x00000040, then 0x00000440 (same index at `LINES` = 16). Expect two misses.
  - Pulse `inval` and re-read 0x00000440. Expect a miss.
- **Reset mid-fill:** assert `reset` while in FILL.
  - Expect `mem_valid` and `ready` low immediately and the counters at 0.
  - After release, expect the next read to miss.
- **Counter saturation:** force `hit_cnt` to 0xFFFE and perform 3 hits. Expect `hit_cnt` to hold at 0xFFFF.
